// File: rtl/bce_pkg.sv
// rtl/bce_pkg.sv - branch condition codes and legality check for the BCE pipeline
package bce_pkg;

  localparam logic [3:0] BF_LTZ = 4'b0010;
  localparam logic [3:0] BF_GEZ = 4'b0011;
  localparam logic [3:0] BF_EQ  = 4'b1000;
  localparam logic [3:0] BF_NE  = 4'b1010;
  localparam logic [3:0] BF_LEZ = 4'b1100;
  localparam logic [3:0] BF_GTZ = 4'b1110;
  localparam logic [3:0] BF_LT  = 4'b0100;
  localparam logic [3:0] BF_LTU = 4'b0101;
  localparam logic [3:0] BF_GE  = 4'b0110;
  localparam logic [3:0] BF_GEU = 4'b0111;

  function automatic logic is_legal_bf(input logic [3:0] code);
    case (code)
      BF_LTZ, BF_GEZ, BF_EQ, BF_NE, BF_LEZ,
      BF_GTZ, BF_LT, BF_LTU, BF_GE, BF_GEU: is_legal_bf = 1'b1;
      default:                              is_legal_bf = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bce_cond_eval.sv
// rtl/bce_cond_eval.sv - combinational branch condition evaluation
module bce_cond_eval
  import bce_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       bf,
  output logic             taken,
  output logic             illegal
);

  logic a_neg;
  logic a_zero;

  assign a_neg   = a[WIDTH-1];
  assign a_zero  = (a == '0);
  assign illegal = !is_legal_bf(bf);

  always_comb begin
    taken = 1'b0;
    case (bf)
      BF_LTZ: taken = a_neg;
      BF_GEZ: taken = !a_neg;
      BF_EQ:  taken = (a == b);
      BF_NE:  taken = (a != b);
      BF_LEZ: taken = a_neg || a_zero;
      BF_GTZ: taken = !a_neg && !a_zero;
      BF_LT:  taken = ($signed(a) < $signed(b));
      BF_LTU: taken = (a < b);
      BF_GE:  taken = ($signed(a) >= $signed(b));
      BF_GEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bce_pipe.sv
// rtl/bce_pipe.sv - two-stage elastic branch resolution unit with flush and mispredict counter
module bce_pipe
  import bce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_bf,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [PC_W-1:0]  in_offset,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [PC_W-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] mispred_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [3:0]       s1_bf_q;
  logic [PC_W-1:0]  s1_pc_q, s1_off_q;
  logic             s1_pred_q;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_taken_q, s2_misp_q, s2_ill_q;
  logic [PC_W-1:0]  s2_target_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv, accept, s2_load;
  logic             eval_taken, eval_ill, misp_d;
  logic [PC_W-1:0]  pc_plus4, target_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || s2_adv);
  assign accept   = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid_q;

  bce_cond_eval #(.WIDTH(WIDTH)) u_eval (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .bf      (s1_bf_q),
    .taken   (eval_taken),
    .illegal (eval_ill)
  );

  // Offset is a word offset; the shifted form drops its top two bits (modulo 2^PC_W).
  assign pc_plus4 = s1_pc_q + PC_W'(4);
  assign target_d = eval_taken ? pc_plus4 + {s1_off_q[PC_W-3:0], 2'b00} : pc_plus4;
  assign misp_d   = !eval_ill && (eval_taken != s1_pred_q);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    if (s2_adv) begin
      s1_valid_d = 1'b0;
      s2_valid_d = s1_valid_q;
    end
    if (accept) s1_valid_d = 1'b1;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
    if (out_valid && out_ready && out_mispredict && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q    <= in_a;
      s1_b_q    <= in_b;
      s1_bf_q   <= in_bf;
      s1_pc_q   <= in_pc;
      s1_off_q  <= in_offset;
      s1_pred_q <= in_pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_taken_q  <= 1'b0;
      s2_misp_q   <= 1'b0;
      s2_ill_q    <= 1'b0;
      s2_target_q <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      if (s2_load) begin
        s2_taken_q  <= eval_taken;
        s2_misp_q   <= misp_d;
        s2_ill_q    <= eval_ill;
        s2_target_q <= target_d;
      end
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_taken      = s2_taken_q;
  assign out_mispredict = s2_valid_q && s2_misp_q;
  assign out_illegal    = s2_ill_q;
  assign out_target     = s2_target_q;
  assign mispred_count  = cnt_q;

endmodule
